// File: rtl/bus_capture_6502.sv
// 6502 bus front-end: synchronises the asynchronous bus into clk, detects completed,
// glitch-filtered write cycles and queues {rs, data} in a small first-word-fall-through FIFO.
module bus_capture_6502 #(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int MIN_HIGH    = 8,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_ext1,
    input  logic             cs,
    input  logic [3:0]       rs,
    input  logic             wren,
    input  logic [7:0]       data_in,
    output logic             wr_valid,
    output logic [3:0]       wr_addr,
    output logic [7:0]       wr_data,
    input  logic             wr_ready,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow,
    input  logic             clr_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int HI_W  = $clog2(MIN_HIGH + 1);
    localparam int SET_W = $clog2(SYNC_STAGES + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    // Bit layout {phi2, cs, wren, rs[3:0], data[7:0]}; the shadow drops the phi2 bit.
    localparam logic [14:0] SYNC_RST   = 15'b0_1_1_0000_00000000;
    localparam logic [13:0] SHADOW_RST = 14'b1_1_0000_00000000;

    logic [14:0]                  w_bus_in;
    logic [SYNC_STAGES-1:0][14:0] r_sync;
    logic [14:0]                  w_sync;
    logic                         w_phi2_s;

    logic [1:0]       r_state;
    logic [SET_W-1:0] r_settle;
    logic [HI_W-1:0]  r_hi_cnt;
    logic [13:0]      r_shadow;

    logic [11:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic [11:0]      w_head;
    logic             w_commit;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    assign w_bus_in = {clk_ext1, cs, wren, rs, data_in};

    // One shared chain keeps every bus bit aligned to the same synchronised phi2 sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{SYNC_RST}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_bus_in};
        end
    end

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_phi2_s = w_sync[14];

    // IDLE first waits for the chain to refill, so a phi2 already high at release is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_settle <= '0;
            r_hi_cnt <= '0;
            r_shadow <= SHADOW_RST;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_settle != SET_W'(SYNC_STAGES)) begin
                        r_settle <= r_settle + SET_W'(1);
                    end else if (!w_phi2_s) begin
                        r_state <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (w_phi2_s) begin
                        r_state  <= ST_HIGH;
                        r_hi_cnt <= '0;
                    end
                end
                ST_HIGH: begin
                    if (w_phi2_s) begin
                        r_shadow <= w_sync[13:0];
                        if (r_hi_cnt != HI_W'(MIN_HIGH)) begin
                            r_hi_cnt <= r_hi_cnt + HI_W'(1);
                        end
                    end else begin
                        r_state <= ST_LOW;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_commit = (r_state == ST_HIGH) && !w_phi2_s && (r_hi_cnt >= HI_W'(MIN_HIGH))
                      && !r_shadow[13] && !r_shadow[12];

    assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop  = (r_count != '0) && wr_ready;
    assign w_push = w_commit && (!w_full || w_pop);
    assign w_drop = w_commit && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shadow[11:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Head is masked while empty so the outputs read zero without resetting the RAM.
    assign w_head     = r_mem[r_rd_ptr];
    assign wr_valid   = (r_count != '0);
    assign wr_addr    = wr_valid ? w_head[11:8] : 4'd0;
    assign wr_data    = wr_valid ? w_head[7:0] : 8'd0;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_bus_capture_6502.sv
// Directed and randomised checks of bus_capture_6502 against a queue-based write model.
module tb_bus_capture_6502;

    logic       clk;
    logic       rst_n;
    logic       clk_ext1;
    logic       cs;
    logic [3:0] rs;
    logic       wren;
    logic [7:0] data_in;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       clr_overflow;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: queue of accepted {rs, data} writes plus sticky drop flag.
    logic [11:0] q[$];
    bit          m_ovf;

    bus_capture_6502 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clk_ext1     (clk_ext1),
        .cs           (cs),
        .rs           (rs),
        .wren         (wren),
        .data_in      (data_in),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A bus cycle commits only when phi2 stayed high long enough and it was a selected write.
    function automatic void model_cycle(input logic c, input logic w, input logic [3:0] r,
                                        input logic [7:0] d, input int hi);
        if (hi >= 10 && !c && !w) begin
            if (q.size() < 4) q.push_back({r, d});
            else m_ovf = 1'b1;
        end
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_count"}, fifo_count, q.size());
        chk({tag, "_valid"}, wr_valid, q.size() != 0);
        chk({tag, "_ovf"}, overflow, m_ovf);
        if (q.size() != 0) begin
            chk({tag, "_addr"}, wr_addr, q[0][11:8]);
            chk({tag, "_data"}, wr_data, q[0][7:0]);
        end
    endtask

    task automatic bus_cycle(input logic c, input logic w, input logic [3:0] r,
                             input logic [7:0] d, input int hi);
        @(negedge clk);
        cs = c; wren = w; rs = r; data_in = d; clk_ext1 = 1'b1;
        repeat (hi) @(negedge clk);
        clk_ext1 = 1'b0;
        repeat (25) @(negedge clk);
        cs = 1'b1; wren = 1'b1;
        model_cycle(c, w, r, d, hi);
    endtask

    task automatic pop_one(input string tag);
        check_state(tag);
        @(negedge clk);
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        $display("pop %s: remaining=%0d", tag, q.size());
    endtask

    initial begin
        logic       c, w, found;
        logic [3:0] r;
        logic [7:0] d;
        int         hi;

        rst_n = 1'b0; clk_ext1 = 1'b0; cs = 1'b1; wren = 1'b1; rs = 4'd0; data_in = 8'd0;
        wr_ready = 1'b0; clr_overflow = 1'b0; m_ovf = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", wr_valid, 1'b0);
        chk("reset_addr", wr_addr, 4'd0);
        chk("reset_data", wr_data, 8'd0);
        chk("reset_count", fifo_count, 3'd0);
        chk("reset_ovf", overflow, 1'b0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // 1: basic write, latency bounded by SYNC_STAGES+2 clocks after phi2 fall.
        @(negedge clk);
        cs = 1'b0; wren = 1'b0; rs = 4'd1; data_in = 8'hA5; clk_ext1 = 1'b1;
        repeat (25) @(negedge clk);
        clk_ext1 = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (wr_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("t1_latency", found, 1'b1);
        repeat (25) @(negedge clk);
        cs = 1'b1; wren = 1'b1;
        q.push_back({4'd1, 8'hA5});
        check_state("t1");
        $display("t1 write addr=1 data=a5 count=%0d", fifo_count);
        pop_one("t1_pop");
        check_state("t1_empty");

        // 2: deselected and read cycles are ignored.
        bus_cycle(1'b1, 1'b0, 4'd2, 8'h11, 25);
        check_state("t2_cs");
        bus_cycle(1'b0, 1'b1, 4'd2, 8'h22, 25);
        check_state("t2_read");
        $display("t2 cs-high and read cycles: count=%0d", fifo_count);

        // 3: a 3-clock phi2 glitch is filtered, the next full cycle commits.
        bus_cycle(1'b0, 1'b0, 4'd3, 8'h33, 3);
        check_state("t3_glitch");
        bus_cycle(1'b0, 1'b0, 4'd4, 8'h44, 25);
        check_state("t3_full");
        $display("t3 glitch filtered, full cycle count=%0d", fifo_count);
        pop_one("t3_pop");

        // 4: overflow on the fifth write, in-order drain, then clear.
        for (int i = 1; i <= 5; i++) begin
            bus_cycle(1'b0, 1'b0, 4'(i + 5), 8'(i), 25);
            $display("t4 write %0d count=%0d ovf=%0b", i, fifo_count, overflow);
        end
        check_state("t4_full");
        for (int i = 0; i < 4; i++) pop_one("t4_pop");
        check_state("t4_drained");
        @(negedge clk); clr_overflow = 1'b1;
        @(negedge clk); clr_overflow = 1'b0;
        m_ovf = 1'b0;
        check_state("t4_clr");

        // 5: full FIFO, wr_ready asserted exactly on the commit edge.
        for (int i = 0; i < 4; i++) bus_cycle(1'b0, 1'b0, 4'(i), 8'(8'h50 + i), 25);
        check_state("t5_pre");
        @(negedge clk);
        cs = 1'b0; wren = 1'b0; rs = 4'hE; data_in = 8'h5E; clk_ext1 = 1'b1;
        repeat (25) @(negedge clk);
        clk_ext1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 wr_ready = 1'b1;
        @(posedge clk);
        #1 wr_ready = 1'b0;
        repeat (25) @(negedge clk);
        cs = 1'b1; wren = 1'b1;
        void'(q.pop_front());
        q.push_back({4'hE, 8'h5E});
        check_state("t5_same_edge");
        $display("t5 push+pop while full: count=%0d ovf=%0b", fifo_count, overflow);
        for (int i = 0; i < 4; i++) pop_one("t5_pop");

        // Randomised bus cycles with interleaved pops and occasional clears.
        for (int n = 0; n < 30; n++) begin
            c  = ($urandom_range(0, 3) == 0);
            w  = ($urandom_range(0, 3) == 0);
            r  = 4'($urandom);
            d  = 8'($urandom);
            hi = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(10, 30));
            bus_cycle(c, w, r, d, hi);
            $display("rnd %0d cs=%0b wren=%0b rs=%0h data=%0h hi=%0d count=%0d", n, c, w, r, d, hi, fifo_count);
            check_state("rnd");
            if ($urandom_range(0, 2) == 0) pop_one("rnd_pop");
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk); clr_overflow = 1'b1;
                @(negedge clk); clr_overflow = 1'b0;
                m_ovf = 1'b0;
                check_state("rnd_clr");
            end
        end

        // 6: reset in the middle of phi2 high, release while still high.
        if (q.size() == 0) bus_cycle(1'b0, 1'b0, 4'h7, 8'h77, 25);
        @(negedge clk);
        cs = 1'b0; wren = 1'b0; rs = 4'h9; data_in = 8'h99; clk_ext1 = 1'b1;
        repeat (10) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        q.delete(); m_ovf = 1'b0;
        chk("t6_rst_valid", wr_valid, 1'b0);
        chk("t6_rst_count", fifo_count, 3'd0);
        chk("t6_rst_ovf", overflow, 1'b0);
        chk("t6_rst_addr", wr_addr, 4'd0);
        chk("t6_rst_data", wr_data, 8'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        clk_ext1 = 1'b0;
        repeat (25) @(negedge clk);
        cs = 1'b1; wren = 1'b1;
        check_state("t6_ignored");
        bus_cycle(1'b0, 1'b0, 4'hC, 8'hC3, 25);
        check_state("t6_after");
        $display("t6 reset mid-cycle, next write count=%0d", fifo_count);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
